// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with synchronous load,
// count enable and a combinational terminal-count output for cascading.
// Optional feature macro: BCD_SAT_EN (saturate at the limits instead of wrapping).
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] step_val;
  logic [W-1:0] next_step;
  logic [W-1:0] load_legal;
  logic         load_bad;
  logic         carry;
  logic         all_nines;
  logic         all_zero;
  logic         at_limit;

  // Decimal ripple step: the carry/borrow propagates upward only
  // through digits sitting at their wrap value (9 going up, 0 going down).
  always_comb begin
    step_val = count;
    carry    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (up) begin
          if (count[4*k +: 4] == 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = count[4*k +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (count[4*k +: 4] == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = count[4*k +: 4] - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  // Limit detection shared by the terminal count and saturation.
  always_comb begin
    all_nines = 1'b1;
    all_zero  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (count[4*k +: 4] != 4'd9) all_nines = 1'b0;
      if (count[4*k +: 4] != 4'd0) all_zero  = 1'b0;
    end
    at_limit = (up & all_nines) | (~up & all_zero);
  end

  // Select the enabled-step value: wrap through, or hold at the limit.
  always_comb begin
`ifdef BCD_SAT_EN
    next_step = at_limit ? count : step_val;
`else
    next_step = step_val;
`endif
  end

  // Legalise the load value digit by digit; any digit above 9 loads as 0
  // and is flagged so the register can never hold a non-BCD digit.
  always_comb begin
    load_legal = '0;
    load_bad   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        load_bad = 1'b1;
      end else begin
        load_legal[4*k +: 4] = load_val[4*k +: 4];
      end
    end
  end

  // Terminal count: high in the cycle whose edge wraps (or sits at) the limit.
  always_comb begin
    tc = en & ~load & ~rst & at_limit;
  end

  // Counter register with priority rst > load > en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_legal;
      load_err <= load_bad;
    end else begin
      load_err <= 1'b0;
      if (en) count <= next_step;
    end
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous load, count enable and a cascadable terminal-count output. It is the general counting element for display and timebase logic: it replaces single-digit decade counters and supports chaining into wider counters via `en`/`tc`. Every digit is always a legal BCD value (0–9).

## Interface
- `DIGITS`, 4, number of BCD digits (1–8); count width is 4*DIGITS bits.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous reset, active-high.
- `en`  input  1  count enable; one step per cycle while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement; sampled only when `en`=1.
- `load`  input  1  synchronous load strobe.
- `load_val`  input  4*DIGITS  value to load; digit k is bits [4k+3:4k], digit 0 least significant.
- `count`  output  4*DIGITS  registered counter value, same digit packing.
- `tc`  output  1  terminal count; combinational; cascade into next stage's `en`.
- `load_err`  output  1  registered; high for one cycle after a load containing a digit > 9.

## Operation
- Priority per cycle: `rst` > `load` > `en` > hold.
- `rst`=1: `count` ← 0, `load_err` ← 0.
- `load`=1: each digit ← `load_val` digit if ≤ 9, otherwise ← 0; `load_err` ← 1 if any digit > 9, else 0. `en` is ignored that cycle.
- `en`=1, `up`=1: decimal increment with ripple. Digit 0 increments; a digit at 9 becomes 0 and carries into the next digit. All-9s (e.g. 9999) wraps to 0.
- `en`=1, `up`=0: decimal decrement with borrow. A digit at 0 becomes 9 and borrows from the next digit. 0 wraps to all-9s.
- `en`=0 and `load`=0: `count` holds.
- `load_err` is 0 in every cycle that is not the cycle after an invalid load.
- `tc` = `en` & ~`load` & ~`rst` & ((`up` & `count`==all-9s) | (~`up` & `count`==0)). It is high exactly in the cycle whose clock edge produces the wrap.
- Cascading: stage N+1 `en` = stage N `tc`, with common `up`, so the stages behave as one wider counter.
- Out-of-range internal digits cannot occur, because every write path is legalised. No decoding of illegal states is required.

## Timing
- Reset and load take effect at the first rising edge where they are sampled high. `count` shows the new value one cycle later (latency 1).
- Count step latency is 1 cycle; one step per enabled cycle, no pipeline bubbles.
- `tc` is combinational from `count`, `en`, `up`, `load` and `rst`. It has no register delay; the path is one digit compare tree plus AND.
- `load_err` is valid in the cycle following the load edge and lasts exactly 1 cycle, unless the next cycle is also an invalid load.
- Direction change: takes effect on the next enabled edge. There is no hidden state.
- Reset asserted mid-count: `count` becomes 0 at that edge regardless of `load`/`en`. `tc` is forced low while `rst`=1.

## Configuration
- `BCD_SAT_EN` defined: saturating mode.
  - Up-count at all-9s holds at all-9s; down-count at 0 holds at 0.
  - `tc` keeps the same equation. It stays high every enabled cycle at the limit (level, not wrap pulse).
- `BCD_SAT_EN` undefined: wrap-around behaviour as in Operation.
- Load, reset and `load_err` are identical in both modes.

## Test plan
All scenarios use DIGITS=2.
- Reset/hold: `rst`=1 for 1 cycle with `count`=57 → `count`=00, `load_err`=0. Then `en`=0 for 5 cycles → `count` stays 00, `tc`=0.
- Up-count and wrap: `en`=1, `up`=1 from 00 for 100 cycles.
  - Sequence 00,01,…,09,10,…,99,00; no hex values (0A–0F) ever appear.
  - `tc`=1 only in the cycle where `count`=99. With `BCD_SAT_EN` defined, `count` stays 99 and `tc` stays 1.
- Down-count with borrow: load 10, then `en`=1, `up`=0 → 09, 08, …, 00, 99. `tc`=1 only while `count`=00 (no wrap with `BCD_SAT_EN`; holds 00).
- Load priority and legalisation:
  - `load`=1, `en`=1, `load_val`=0x4C → `count`=40, `load_err`=1 for one cycle.
  - `load_val`=0x73 → `count`=73, `load_err`=0.
- Cascade: two instances with stage0 `tc` driving stage1 `en`, stage1 `en` fed from stage0 `tc`, `up`=1, counting from 0099 → next edge 0100. Stage0 `tc` is high only at x99 values.
- Reset mid-operation: `rst`=1 in the same cycle as `load`=1 (`load_val`=0x55) and `en`=1 → `count`=00, `load_err`=0, `tc`=0.
